// File: rtl/conv_seq_ctrl.sv
// Sequencer for a sliding-window convolution: walks X/F read addresses, drives the MAC
// and hands each y downstream. Optional abort input enabled by define CONV_SEQ_ABORT_EN.
module conv_seq_ctrl #(
    parameter int X_SIZE   = 8,
    parameter int F_SIZE   = 4,
    parameter int X_ADDR_W = $clog2(X_SIZE),
    parameter int F_ADDR_W = $clog2(F_SIZE)
) (
    input  logic                clk,
    input  logic                reset,
`ifdef CONV_SEQ_ABORT_EN
    input  logic                abort,
`endif
    input  logic                start,
    output logic [X_ADDR_W-1:0] x_addr,
    output logic [F_ADDR_W-1:0] f_addr,
    output logic                mac_clr,
    output logic                mac_en,
    output logic                m_valid_y,
    input  logic                m_ready_y,
    output logic                busy,
    output logic                done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MAC   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_OUT   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [F_ADDR_W-1:0] K_LAST  = F_ADDR_W'(F_SIZE - 1);
    localparam logic [X_ADDR_W-1:0] XB_LAST = X_ADDR_W'(X_SIZE - F_SIZE);

    logic [2:0]          state, state_nxt;
    logic [X_ADDR_W-1:0] xb, xb_nxt;
    logic [F_ADDR_W-1:0] k, k_nxt;
    logic                abort_pulse;
`ifdef CONV_SEQ_ABORT_EN
    logic                abort_go;
`endif

    always_comb begin
        state_nxt = state;
        xb_nxt    = xb;
        k_nxt     = k;
`ifdef CONV_SEQ_ABORT_EN
        abort_go  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_MAC;
                    xb_nxt    = '0;
                    k_nxt     = '0;
                end
            end
            ST_MAC: begin
                if (k == K_LAST) begin
                    state_nxt = ST_DRAIN;
                    k_nxt     = '0;
                end else begin
                    k_nxt = k + 1'b1;
                end
            end
            ST_DRAIN: state_nxt = ST_OUT;
            ST_OUT: begin
                if (m_ready_y) begin
                    if (xb == XB_LAST) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_MAC;
                        xb_nxt    = xb + 1'b1;
                        k_nxt     = '0;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
`ifdef CONV_SEQ_ABORT_EN
        // DONE already pulses done itself, so abort there needs no extra pulse
        if (abort && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
            xb_nxt    = '0;
            k_nxt     = '0;
            abort_go  = (state != ST_DONE);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            xb    <= '0;
            k     <= '0;
        end else begin
            state <= state_nxt;
            xb    <= xb_nxt;
            k     <= k_nxt;
        end
    end

`ifdef CONV_SEQ_ABORT_EN
    // done for an aborted job is raised in the IDLE cycle that follows the abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            abort_pulse <= 1'b0;
        end else begin
            abort_pulse <= abort_go;
        end
    end
`else
    assign abort_pulse = 1'b0;
`endif

    // Memory has one cycle of read latency, so the MAC enable trails the address by one
    always_comb begin
        x_addr    = (state == ST_MAC) ? (xb + X_ADDR_W'(k)) : '0;
        f_addr    = (state == ST_MAC) ? k : '0;
        mac_clr   = (state == ST_MAC) && (k == '0);
        mac_en    = ((state == ST_MAC) && (k != '0)) || (state == ST_DRAIN);
        m_valid_y = (state == ST_OUT);
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE) || abort_pulse;
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: queue-based job model plus directed checks.
module tb_conv_seq_ctrl;

    localparam int X    = 8;
    localparam int F    = 4;
    localparam int XW   = 3;
    localparam int FW   = 2;
    localparam int NWIN = X - F + 1;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [FW-1:0] f;
        logic          clr;
        logic          en;
        logic          vld;
        logic          busy;
        logic          done;
    } ov_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [XW-1:0] x_addr;
    logic [FW-1:0] f_addr;
    logic          mac_clr;
    logic          mac_en;
    logic          m_valid_y;
    logic          m_ready_y;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    conv_seq_ctrl #(.X_SIZE(X), .F_SIZE(F), .X_ADDR_W(XW), .F_ADDR_W(FW)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef CONV_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .x_addr    (x_addr),
        .f_addr    (f_addr),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .m_valid_y (m_valid_y),
        .m_ready_y (m_ready_y),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a job is a list of per-cycle output vectors
    ov_t q[$];
    bit  m_act;
    int  m_win;
    ov_t m_c, m_v;
    bit  m_idle;

    function automatic ov_t cur_exp();
        ov_t v;
        v = '0;
        if (q.size() > 0) v = q[0];
        else if (m_act) begin
            v.vld  = 1'b1;
            v.busy = 1'b1;
        end
        return v;
    endfunction

    task automatic push_window(input int w);
        ov_t v;
        for (int kk = 0; kk < F; kk++) begin
            v      = '0;
            v.x    = XW'(w + kk);
            v.f    = FW'(kk);
            v.clr  = (kk == 0);
            v.en   = (kk != 0);
            v.busy = 1'b1;
            q.push_back(v);
        end
        v      = '0;
        v.en   = 1'b1;
        v.busy = 1'b1;
        q.push_back(v);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_act = 1'b0;
            m_win = 0;
        end else begin
            m_c    = cur_exp();
            m_idle = !m_c.busy;
            if (abort && m_c.busy && !m_c.done) begin
                q.delete();
                m_act  = 1'b0;
                m_v    = '0;
                m_v.done = 1'b1;
                q.push_back(m_v);
            end else begin
                if (q.size() > 0) void'(q.pop_front());
                else if (m_act && m_ready_y) begin
                    if (m_win == NWIN - 1) begin
                        m_act  = 1'b0;
                        m_v    = '0;
                        m_v.busy = 1'b1;
                        m_v.done = 1'b1;
                        q.push_back(m_v);
                    end else begin
                        m_win++;
                        push_window(m_win);
                    end
                end
                if (m_idle && start) begin
                    m_act = 1'b1;
                    m_win = 0;
                    push_window(0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            expect_eq("cycle outputs",
                      int'({x_addr, f_addr, mac_clr, mac_en, m_valid_y, busy, done}),
                      int'(cur_exp()));
        end
    end

    task automatic wait_sig(input int sel, input int limit, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if ((sel == 0 && m_valid_y) || (sel == 1 && done)) ok = 1'b1;
        end
        expect_eq({name, " seen"}, int'(ok), 1);
    endtask

    initial begin
        int first_v, hs, clr, tc, done_n, done_c, last_hs;
        bit ok;
        start     = 1'b0;
        m_ready_y = 1'b0;
        abort     = 1'b0;
        reset     = 1'b0;
        repeat (2) @(negedge clk);
        #1 expect_eq("reset outputs",
                     int'({x_addr, f_addr, mac_clr, mac_en, m_valid_y, busy, done}), 0);
        @(negedge clk);
        #2 reset = 1'b1;
        chk_en = 1'b1;

        // ---------------- free-running job: latency, count, done and window-3 trace
        @(negedge clk);
        start = 1'b1; m_ready_y = 1'b1;
        first_v = -1; hs = 0; clr = 0; tc = 4; done_n = 0; done_c = -1; last_hs = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (m_valid_y) begin
                if (first_v < 0) first_v = c;
                expect_eq("output spacing", c, 6 + 6 * hs);
                hs++;
                last_hs = c;
            end
            if (mac_clr) begin
                clr++;
                if (clr == 4) tc = 0;
            end
            if (clr == 4 && tc < 4) begin
                expect_eq("win3 x_addr", int'(x_addr), 3 + tc);
                expect_eq("win3 f_addr", int'(f_addr), tc);
                expect_eq("win3 mac_clr", int'(mac_clr), (tc == 0) ? 1 : 0);
                tc++;
            end
            if (done) begin
                done_n++;
                done_c = c;
            end
        end
        expect_eq("first valid cycle", first_v, 6);
        expect_eq("outputs per job", hs, 5);
        expect_eq("done pulses", done_n, 1);
        expect_eq("last handshake cycle", last_hs, 30);
        expect_eq("done cycle", done_c, 31);

        // ---------------- stall during the 2nd output
        @(negedge clk);
        start = 1'b1; m_ready_y = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_sig(0, 20, "1st output");
        m_ready_y = 1'b1;
        @(negedge clk);
        m_ready_y = 1'b0;
        wait_sig(0, 20, "2nd output");
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            expect_eq("stall m_valid_y", int'(m_valid_y), 1);
            expect_eq("stall mac_en", int'(mac_en), 0);
            expect_eq("stall x_addr", int'(x_addr), 0);
        end
        m_ready_y = 1'b1;
        wait_sig(1, 100, "stall job done");
        m_ready_y = 1'b0;

        // ---------------- reset in the 3rd window's MAC
        @(negedge clk);
        start = 1'b1; m_ready_y = 1'b1;
        clr = 0;
        for (int c = 1; c <= 40 && clr < 3; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (mac_clr) clr++;
        end
        expect_eq("3rd window reached", clr, 3);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 expect_eq("mid-job reset outputs",
                     int'({x_addr, f_addr, mac_clr, mac_en, m_valid_y, busy, done}), 0);
        repeat (3) begin
            @(negedge clk);
            expect_eq("no done in reset", int'(done), 0);
        end
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        expect_eq("no done after reset", int'(done), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_eq("restart x_addr", int'(x_addr), 0);
        expect_eq("restart mac_clr", int'(mac_clr), 1);
        wait_sig(1, 100, "restart job done");

        // ---------------- start held high through a whole job
        @(negedge clk);
        start = 1'b1; m_ready_y = 1'b1;
        hs = 0; ok = 1'b0;
        for (int c = 1; c <= 100 && !ok; c++) begin
            @(negedge clk);
            if (m_valid_y) hs++;
            if (done) ok = 1'b1;
        end
        expect_eq("held-start job done", int'(ok), 1);
        expect_eq("held-start outputs", hs, 5);
        @(negedge clk);
        expect_eq("idle between jobs", int'(busy), 0);
        @(negedge clk);
        expect_eq("second job busy", int'(busy), 1);
        expect_eq("second job x_addr", int'(x_addr), 0);
        start = 1'b0;
        wait_sig(1, 100, "second job done");

`ifdef CONV_SEQ_ABORT_EN
        // ---------------- abort while an output is waiting
        @(negedge clk);
        start = 1'b1; m_ready_y = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_sig(0, 20, "abort target output");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        expect_eq("abort busy", int'(busy), 0);
        expect_eq("abort m_valid_y", int'(m_valid_y), 0);
        expect_eq("abort mac_en", int'(mac_en), 0);
        expect_eq("abort done", int'(done), 1);
        @(negedge clk);
        expect_eq("abort done width", int'(done), 0);
`endif

        // ---------------- randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 7) == 0);
            m_ready_y = $urandom_range(0, 1) != 0;
`ifdef CONV_SEQ_ABORT_EN
            abort     = ($urandom_range(0, 39) == 0);
`endif
            if ($urandom_range(0, 599) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                #2 reset = 1'b1;
            end
        end
        start = 1'b0; abort = 1'b0; m_ready_y = 1'b1;
        repeat (60) @(negedge clk);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 Parameter X_SIZE, default 8, number of X samples per job.
REQ-002 Parameter F_SIZE, default 4, number of filter taps; F_SIZE SHALL be at least 2 and at most X_SIZE.
REQ-003 Parameter X_ADDR_W, default $clog2(X_SIZE), X address width.
REQ-004 Parameter F_ADDR_W, default $clog2(F_SIZE), F address width.
REQ-005 Port clk  input  1  the single clock; all logic is rising-edge.
REQ-006 Port reset  input  1  asynchronous, active-low reset.
REQ-007 Port start  input  1  X and F memories both full; sampled only in IDLE.
REQ-008 Port x_addr  output  X_ADDR_W  X memory read address.
REQ-009 Port f_addr  output  F_ADDR_W  F memory read address.
REQ-010 Port mac_clr  output  1  synchronous clear of the accumulator.
REQ-011 Port mac_en  output  1  accumulate the current x*f product.
REQ-012 Port m_valid_y  output  1  accumulator holds a valid y.
REQ-013 Port m_ready_y  input  1  downstream accepts y.
REQ-014 Port busy  output  1  high in every state except IDLE.
REQ-015 Port done  output  1  one-cycle pulse at job end; the memory write controllers use it to rearm.

Function
REQ-016 The FSM SHALL have states IDLE, MAC, DRAIN, OUT and DONE.
REQ-017 IDLE->MAC on start=1; the window base xb and tap index k SHALL load 0.
REQ-018 In MAC: x_addr=xb+k, f_addr=k, k increments each cycle; mac_clr=1 only in the k=0 cycle; after k=F_SIZE-1 go to DRAIN.
REQ-019 Memory read latency is 1 cycle; mac_en SHALL be high exactly in the F_SIZE cycles following each MAC address cycle (MAC cycles 2..F_SIZE plus DRAIN).
REQ-020 DRAIN SHALL always last 1 cycle, then go to OUT.
REQ-021 In OUT: m_valid_y=1, mac_en=0, mac_clr=0; hold until m_valid_y&&m_ready_y.
REQ-022 On an OUT handshake with xb<X_SIZE-F_SIZE: xb++, k=0, go to MAC.
REQ-023 On an OUT handshake with xb=X_SIZE-F_SIZE: go to DONE.
REQ-024 DONE SHALL assert done=1 for exactly 1 cycle, then go to IDLE.
REQ-025 Each job SHALL produce exactly X_SIZE-F_SIZE+1 outputs.
REQ-026 First m_valid_y SHALL rise F_SIZE+2 cycles after start is sampled; each later output rises F_SIZE+2 cycles after the previous handshake.
REQ-027 start SHALL be ignored outside IDLE, including in DONE.
REQ-028 m_ready_y outside OUT SHALL have no effect.
REQ-029 m_valid_y, once high, SHALL NOT drop until the handshake completes.
REQ-030 x_addr SHALL never exceed X_SIZE-1 and f_addr SHALL never exceed F_SIZE-1; outside MAC both SHALL read 0.

Reset
REQ-031 While reset=0: state=IDLE, xb=0, k=0, and all outputs 0, asynchronously.
REQ-032 Reset asserted mid-job SHALL abandon the job without pulsing done.
REQ-033 After reset releases, the first start SHALL begin a fresh job at xb=0.

Configuration
REQ-034 Macro CONV_SEQ_ABORT_EN, when defined, SHALL add port abort (input, 1).
REQ-035 With CONV_SEQ_ABORT_EN defined, abort=1 in any non-IDLE state SHALL go to IDLE next cycle with mac_en=0 and m_valid_y=0, and pulse done for 1 cycle so the memories rearm.
REQ-036 With CONV_SEQ_ABORT_EN undefined, no abort port SHALL exist and behaviour SHALL be exactly REQ-016..REQ-030.

Verification
REQ-037 Defaults, start pulse, m_ready_y tied 1 -> 5 outputs; m_valid_y first high 6 cycles after start; done once, 1 cycle after the 5th handshake.
REQ-038 Defaults, m_ready_y held 0 for 10 cycles during the 2nd output -> m_valid_y stays high; mac_en=0; x_addr=0 throughout the stall.
REQ-039 X_SIZE=8, F_SIZE=4 address trace -> window 3 issues x_addr 3,4,5,6 with f_addr 0,1,2,3; mac_clr coincides with x_addr=3.
REQ-040 reset driven low during the 3rd window's MAC state -> all outputs 0 immediately; no done; next start restarts at x_addr=0.
REQ-041 start held high through a whole job -> exactly one job runs; a second job begins only after IDLE is re-entered.
REQ-042 CONV_SEQ_ABORT_EN defined, abort=1 in OUT -> IDLE next cycle; m_valid_y=0; done pulsed once.
